// File: rtl/btn_event_pkg.sv
// Shared state encoding for the button event decoder.
package btn_event_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_DOWN  = 3'd1,
        S_LONG  = 3'd2,
        S_GAP   = 3'd3,
        S_DOWN2 = 3'd4
    } state_t;

endpackage

// File: rtl/btn_edge_det.sv
// Two-flop level register that turns the debounced level into rise/fall pulses.
module btn_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic lvl_q;
    logic lvl_p;

    // Register the level twice so edges are judged on two aligned samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_q <= 1'b0;
            lvl_p <= 1'b0;
        end else begin
            lvl_q <= level;
            lvl_p <= lvl_q;
        end
    end

    assign rise = lvl_q & ~lvl_p;
    assign fall = ~lvl_q & lvl_p;

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies a debounced button level into press/release/click/double/long strobes.
module btn_event_decoder
    import btn_event_pkg::*;
#(
    parameter int LONG_CNT = 8,
    parameter int DBL_CNT  = 6,
    parameter int CNT_W    = 26
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_level,
    output logic               o_press,
    output logic               o_release,
    output logic               o_click,
    output logic               o_dbl_click,
    output logic               o_long,
    output logic [STATE_W-1:0] o_state,
    output logic               o_busy
);

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DBL_TERM  = CNT_W'(DBL_CNT - 1);

    logic             rise;
    logic             fall;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             press_nxt;
    logic             release_nxt;
    logic             click_nxt;
    logic             dbl_nxt;
    logic             long_nxt;

    btn_edge_det u_edge (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .level (i_level),
        .rise  (rise),
        .fall  (fall)
    );

    // Next-state and strobe decode; an edge always beats a terminal count.
    always_comb begin
        state_nxt   = state;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        click_nxt   = 1'b0;
        dbl_nxt     = 1'b0;
        long_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_nxt = S_DOWN;
                    press_nxt = 1'b1;
                end
            end
            S_DOWN: begin
                if (fall) begin
                    state_nxt   = S_GAP;
                    release_nxt = 1'b1;
                end else if (cnt == LONG_TERM) begin
                    state_nxt = S_LONG;
                    long_nxt  = 1'b1;
                end
            end
            S_LONG: begin
                if (fall) begin
                    state_nxt   = S_IDLE;
                    release_nxt = 1'b1;
                end
            end
            S_GAP: begin
                if (rise) begin
                    state_nxt = S_DOWN2;
                    press_nxt = 1'b1;
                    dbl_nxt   = 1'b1;
                end else if (cnt == DBL_TERM) begin
                    state_nxt = S_IDLE;
                    click_nxt = 1'b1;
                end
            end
            S_DOWN2: begin
                if (fall) begin
                    state_nxt   = S_IDLE;
                    release_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and strobe registers, so every output changes on the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            o_press     <= 1'b0;
            o_release   <= 1'b0;
            o_click     <= 1'b0;
            o_dbl_click <= 1'b0;
            o_long      <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_press     <= press_nxt;
            o_release   <= release_nxt;
            o_click     <= click_nxt;
            o_dbl_click <= dbl_nxt;
            o_long      <= long_nxt;
        end
    end

    // Shared hold/gap timer: restarts on every state change, runs only while timing.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (state == S_DOWN || state == S_GAP) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign o_state = state;
    assign o_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_btn_event_decoder.sv
// Self-checking bench for btn_event_decoder using a timer-based gesture model.
module tb_btn_event_decoder;

    localparam int LONG_CNT = 8;
    localparam int DBL_CNT  = 6;
    localparam int CNT_W    = 26;

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_level = 1'b0;
    logic       o_press;
    logic       o_release;
    logic       o_click;
    logic       o_dbl_click;
    logic       o_long;
    logic [2:0] o_state;
    logic       o_busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: sampled level history plus "cycles since press / since release" timers.
    logic       m_h0 = 1'b0;
    logic       m_h1 = 1'b0;
    int         m_held = -1;
    int         m_gap = -1;
    logic       m_second = 1'b0;
    logic       m_longed = 1'b0;
    logic [8:0] exp_vec = '0;

    int q_press[$];
    int q_rel[$];
    int q_click[$];
    int q_dbl[$];
    int q_long[$];

    btn_event_decoder #(
        .LONG_CNT (LONG_CNT),
        .DBL_CNT  (DBL_CNT),
        .CNT_W    (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_level     (i_level),
        .o_press     (o_press),
        .o_release   (o_release),
        .o_click     (o_click),
        .o_dbl_click (o_dbl_click),
        .o_long      (o_long),
        .o_state     (o_state),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    // Cycle counter used to timestamp strobes.
    always @(posedge clk) cyc <= cyc + 1;

    // Gesture model: derive expected strobes from elapsed-time rules.
    always @(posedge clk) begin : model
        int   held;
        int   gap;
        logic second;
        logic longed;
        logic rise_m;
        logic fall_m;
        logic p, r, c, d, l;
        int   st;
        if (!i_rst_n) begin
            m_h0     <= 1'b0;
            m_h1     <= 1'b0;
            m_held   <= -1;
            m_gap    <= -1;
            m_second <= 1'b0;
            m_longed <= 1'b0;
            exp_vec  <= '0;
        end else begin
            rise_m = m_h0 && !m_h1;
            fall_m = !m_h0 && m_h1;
            held = m_held;
            gap = m_gap;
            second = m_second;
            longed = m_longed;
            p = 0; r = 0; c = 0; d = 0; l = 0;
            if (held >= 0) begin
                held = held + 1;
                if (fall_m) begin
                    r = 1;
                    gap = (!second && !longed) ? 0 : -1;
                    held = -1;
                end else if (!second && !longed && held == LONG_CNT) begin
                    l = 1;
                    longed = 1;
                end
            end else if (gap >= 0) begin
                gap = gap + 1;
                if (rise_m) begin
                    p = 1; d = 1;
                    gap = -1; held = 0; second = 1; longed = 0;
                end else if (gap == DBL_CNT) begin
                    c = 1;
                    gap = -1;
                end
            end else if (rise_m) begin
                p = 1;
                held = 0; second = 0; longed = 0;
            end
            st = (held >= 0) ? (second ? 4 : (longed ? 2 : 1)) : ((gap >= 0) ? 3 : 0);
            m_held   <= held;
            m_gap    <= gap;
            m_second <= second;
            m_longed <= longed;
            exp_vec  <= {p, r, c, d, l, (st != 0), 3'(st)};
            m_h1     <= m_h0;
            m_h0     <= i_level;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance one cycle, compare every output with the model and log strobes.
    task automatic tick();
        logic [8:0] got;
        @(negedge clk);
        got = {o_press, o_release, o_click, o_dbl_click, o_long, o_busy, o_state};
        vectors++;
        if (got !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL cycle %0d outputs: got %b, expected %b", cyc, got, exp_vec);
        end
        if (o_press)     q_press.push_back(cyc);
        if (o_release)   q_rel.push_back(cyc);
        if (o_click)     q_click.push_back(cyc);
        if (o_dbl_click) q_dbl.push_back(cyc);
        if (o_long)      q_long.push_back(cyc);
    endtask

    task automatic applyStimulus(input logic level, input int cycles);
        i_level = level;
        repeat (cycles) tick();
    endtask

    int bp, br, bc, bd, bl, t0;

    task automatic snapBases();
        bp = q_press.size();
        br = q_rel.size();
        bc = q_click.size();
        bd = q_dbl.size();
        bl = q_long.size();
    endtask

    initial begin
        // Reset with the button released.
        i_rst_n = 1'b0;
        i_level = 1'b0;
        repeat (3) tick();
        checkOutput("reset_state", int'(o_state), 0);
        checkOutput("reset_busy", int'(o_busy), 0);
        checkOutput("reset_strobes", int'({o_press, o_release, o_click, o_dbl_click, o_long}), 0);
        i_rst_n = 1'b1;
        applyStimulus(1'b0, 2);

        // Short click.
        snapBases();
        t0 = cyc;
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 12);
        checkOutput("click_press_count", q_press.size() - bp, 1);
        if (q_press.size() > bp) checkOutput("click_press_latency", q_press[bp] - t0, 2);
        if (q_press.size() > bp && q_rel.size() > br)
            checkOutput("click_release_delay", q_rel[br] - q_press[bp], 3);
        checkOutput("click_count", q_click.size() - bc, 1);
        if (q_click.size() > bc && q_rel.size() > br)
            checkOutput("click_after_release", q_click[bc] - q_rel[br], DBL_CNT);
        checkOutput("click_no_long", q_long.size() - bl, 0);

        // Held exactly LONG_CNT cycles: still a short press.
        snapBases();
        applyStimulus(1'b1, 8);
        applyStimulus(1'b0, 12);
        checkOutput("hold8_no_long", q_long.size() - bl, 0);
        checkOutput("hold8_click", q_click.size() - bc, 1);
        if (q_press.size() > bp && q_rel.size() > br)
            checkOutput("hold8_release_delay", q_rel[br] - q_press[bp], 8);

        // Held one cycle longer: long press, no click.
        snapBases();
        applyStimulus(1'b1, 9);
        applyStimulus(1'b0, 12);
        checkOutput("hold9_long", q_long.size() - bl, 1);
        if (q_long.size() > bl && q_press.size() > bp)
            checkOutput("hold9_long_delay", q_long[bl] - q_press[bp], 8);
        if (q_long.size() > bl && q_rel.size() > br)
            checkOutput("hold9_release_after_long", q_rel[br] - q_long[bl], 1);
        checkOutput("hold9_no_click", q_click.size() - bc, 0);

        // Double click with a short gap.
        snapBases();
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 12);
        checkOutput("dbl_press_count", q_press.size() - bp, 2);
        checkOutput("dbl_release_count", q_rel.size() - br, 2);
        checkOutput("dbl_count", q_dbl.size() - bd, 1);
        checkOutput("dbl_no_click", q_click.size() - bc, 0);
        if (q_dbl.size() > bd && q_press.size() > bp + 1)
            checkOutput("dbl_with_press", q_dbl[bd] - q_press[bp + 1], 0);

        // Second rise lands on the last gap cycle: still a double click.
        snapBases();
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 6);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 12);
        checkOutput("gap_edge_dbl", q_dbl.size() - bd, 1);
        checkOutput("gap_edge_no_click", q_click.size() - bc, 0);
        if (q_dbl.size() > bd && q_rel.size() > br)
            checkOutput("gap_edge_dbl_delay", q_dbl[bd] - q_rel[br], 6);

        // One cycle later: click, then a fresh press from idle.
        snapBases();
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 7);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 12);
        checkOutput("gap_late_no_dbl", q_dbl.size() - bd, 0);
        checkOutput("gap_late_clicks", q_click.size() - bc, 2);
        if (q_click.size() > bc && q_press.size() > bp + 1)
            checkOutput("gap_late_repress", q_press[bp + 1] - q_click[bc], 1);

        // Reset while the button is held down.
        applyStimulus(1'b1, 3);
        i_rst_n = 1'b0;
        tick();
        checkOutput("midrst_state", int'(o_state), 0);
        checkOutput("midrst_busy", int'(o_busy), 0);
        i_rst_n = 1'b1;
        snapBases();
        t0 = cyc;
        applyStimulus(1'b1, 4);
        checkOutput("midrst_press_count", q_press.size() - bp, 1);
        if (q_press.size() > bp) checkOutput("midrst_repress_latency", q_press[bp] - t0, 2);
        checkOutput("midrst_no_release", q_rel.size() - br, 0);
        checkOutput("midrst_no_click", q_click.size() - bc, 0);
        applyStimulus(1'b0, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
